// File: rtl/uart_rx_if.sv
// uart_rx_if: serial input and receive-side result/strobe bundle for uart_rx.
// master = host/line side (drives uart_rxd), slave = the receiver itself.
interface uart_rx_if;
    logic       uart_rxd;
    logic [7:0] uart_rx_data;
    logic       uart_rx_valid;
    logic       uart_rx_busy;
    logic       uart_rx_frame_err;
    logic       uart_rx_parity_err;

    modport master (
        output uart_rxd,
        input  uart_rx_data,
        input  uart_rx_valid,
        input  uart_rx_busy,
        input  uart_rx_frame_err,
        input  uart_rx_parity_err
    );

    modport slave (
        input  uart_rxd,
        output uart_rx_data,
        output uart_rx_valid,
        output uart_rx_busy,
        output uart_rx_frame_err,
        output uart_rx_parity_err
    );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver (8E1 when UART_RX_PARITY_EN is defined).
// Deserialises a synchronised copy of uart_rxd LSB first, sampling at bit
// centres, and reports each frame with a single one-cycle strobe: valid,
// frame_err (stop bit low) or parity_err (even parity mismatch).
// Reset is asynchronous and active-high despite the port name reset_n.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | line idle, waiting for a 1->0 edge on the synchronised input
// START  | counting to the middle of the start bit to reject glitches
// DATA   | sampling 8 data bits, one per bit period, LSB first
// PARITY | sampling the even parity bit (UART_RX_PARITY_EN only)
// STOP   | sampling the stop bit and issuing the result strobe
module uart_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic     clk,
    input  logic     reset_n,
    uart_rx_if.slave rx_if
);

    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] CNT_HALF_TC = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_BIT_TC  = CNT_W'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd4
    } state_t;
`endif

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   w_rxd_s;
    logic                   w_fall;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_next_cnt;
    logic [2:0]             r_bit_idx;
    logic [2:0]             w_next_bit_idx;
    logic [7:0]             r_shreg;
    logic [7:0]             w_next_shreg;
    logic [7:0]             r_data;
    logic [7:0]             w_next_data;
    logic                   r_valid;
    logic                   w_next_valid;
    logic                   r_frame_err;
    logic                   w_next_frame_err;
    logic                   w_cnt_bit_tc;
    logic                   w_cnt_half_tc;

`ifdef UART_RX_PARITY_EN
    logic                   r_par_bit;
    logic                   w_next_par_bit;
    logic                   r_parity_err;
    logic                   w_next_parity_err;
    logic                   w_par_bad;
`endif

    assign w_rxd_s       = r_sync[SYNC_STAGES-1];
    assign w_fall        = r_prev & ~w_rxd_s;
    assign w_cnt_bit_tc  = (r_cnt == CNT_BIT_TC);
    assign w_cnt_half_tc = (r_cnt == CNT_HALF_TC);

`ifdef UART_RX_PARITY_EN
    // Even parity: XOR over data and parity bit must come out 0.
    assign w_par_bad = ^{r_par_bit, r_shreg};
`endif

    // Input synchroniser and previous-sample register for edge detection;
    // both reset to the idle-high level so reset never looks like a start edge.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            r_sync <= '1;
            r_prev <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rx_if.uart_rxd};
            r_prev <= w_rxd_s;
        end
    end

    // State, counters, shift register and registered result strobes.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shreg     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bit    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_state     <= w_next_state;
            r_cnt       <= w_next_cnt;
            r_bit_idx   <= w_next_bit_idx;
            r_shreg     <= w_next_shreg;
            r_data      <= w_next_data;
            r_valid     <= w_next_valid;
            r_frame_err <= w_next_frame_err;
`ifdef UART_RX_PARITY_EN
            r_par_bit    <= w_next_par_bit;
            r_parity_err <= w_next_parity_err;
`endif
        end
    end

    // Next-state and datapath decode; strobes default low so each lasts one cycle.
    always_comb begin
        w_next_state     = r_state;
        w_next_cnt       = r_cnt;
        w_next_bit_idx   = r_bit_idx;
        w_next_shreg     = r_shreg;
        w_next_data      = r_data;
        w_next_valid     = 1'b0;
        w_next_frame_err = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_next_par_bit    = r_par_bit;
        w_next_parity_err = 1'b0;
`endif

        case (r_state)
            S_IDLE: begin
                // Edge-triggered: a line stuck low after a bad stop bit
                // cannot restart the receiver until it has gone high again.
                if (w_fall) begin
                    w_next_state = S_START;
                    w_next_cnt   = '0;
                end
            end

            S_START: begin
                if (w_cnt_half_tc) begin
                    w_next_cnt = '0;
                    if (!w_rxd_s) begin
                        w_next_state   = S_DATA;
                        w_next_bit_idx = '0;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end else begin
                    w_next_cnt = r_cnt + 1'b1;
                end
            end

            S_DATA: begin
                if (w_cnt_bit_tc) begin
                    w_next_cnt   = '0;
                    w_next_shreg = {w_rxd_s, r_shreg[7:1]};
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_next_state = S_PARITY;
`else
                        w_next_state = S_STOP;
`endif
                    end else begin
                        w_next_bit_idx = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_next_cnt = r_cnt + 1'b1;
                end
            end

`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (w_cnt_bit_tc) begin
                    w_next_cnt     = '0;
                    w_next_par_bit = w_rxd_s;
                    w_next_state   = S_STOP;
                end else begin
                    w_next_cnt = r_cnt + 1'b1;
                end
            end
`endif

            S_STOP: begin
                // Leave at the stop mid-bit so a start edge half a bit
                // later is already seen from IDLE.
                if (w_cnt_bit_tc) begin
                    w_next_cnt   = '0;
                    w_next_state = S_IDLE;
                    if (!w_rxd_s) begin
                        w_next_frame_err = 1'b1;
`ifdef UART_RX_PARITY_EN
                    end else if (w_par_bad) begin
                        w_next_parity_err = 1'b1;
`endif
                    end else begin
                        w_next_data  = r_shreg;
                        w_next_valid = 1'b1;
                    end
                end else begin
                    w_next_cnt = r_cnt + 1'b1;
                end
            end

            default: begin
                w_next_state = S_IDLE;
                w_next_cnt   = '0;
            end
        endcase
    end

    assign rx_if.uart_rx_data      = r_data;
    assign rx_if.uart_rx_valid     = r_valid;
    assign rx_if.uart_rx_frame_err = r_frame_err;
    assign rx_if.uart_rx_busy      = (r_state != S_IDLE);
`ifdef UART_RX_PARITY_EN
    assign rx_if.uart_rx_parity_err = r_parity_err;
`else
    assign rx_if.uart_rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed, table-driven bench for uart_rx at 16 clocks per bit.
module tb_uart_rx;

    localparam int CPB  = 16;
    localparam int SYNC = 2;
    localparam int HALF = CPB / 2;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 10;
`else
    localparam int NBITS = 9;
`endif
    // Cycles from driving the start bit low to valid/frame_err/busy falling:
    // synchroniser delay + half bit + remaining bit periods + output register.
    localparam int LAT = SYNC + HALF + NBITS * CPB + 1;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_valid;
        int         exp_ferr;
        logic [7:0] exp_data;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    int   cyc = 0;

    int   n_checks = 0;
    int   n_pass = 0;

    int   n_valid = 0;
    int   n_ferr = 0;
    int   n_perr = 0;
    int   n_overlap = 0;
    int   valid_cyc = 0;
    int   ferr_cyc = 0;
    int   busy_rise_cyc = 0;
    int   busy_fall_cyc = 0;
    logic prev_busy = 1'b0;
    logic [7:0] got_log [64];

    int   b_valid, b_ferr, b_perr;
    int   t0;
    vec_t vecs [6];

    uart_rx_if bus ();

    uart_rx #(
        .CLKS_PER_BIT (CPB),
        .SYNC_STAGES  (SYNC)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .rx_if   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe/busy monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (bus.uart_rx_valid) begin
            got_log[n_valid % 64] <= bus.uart_rx_data;
            n_valid   <= n_valid + 1;
            valid_cyc <= cyc;
        end
        if (bus.uart_rx_frame_err) begin
            n_ferr   <= n_ferr + 1;
            ferr_cyc <= cyc;
        end
        if (bus.uart_rx_parity_err) n_perr <= n_perr + 1;
        if ((int'(bus.uart_rx_valid) + int'(bus.uart_rx_frame_err) + int'(bus.uart_rx_parity_err)) > 1)
            n_overlap <= n_overlap + 1;
        if (bus.uart_rx_busy && !prev_busy) busy_rise_cyc <= cyc;
        if (!bus.uart_rx_busy && prev_busy) busy_fall_cyc <= cyc;
        prev_busy <= bus.uart_rx_busy;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic b);
        bus.uart_rxd = b;
        tick(CPB);
    endtask

    // Sends one frame starting right after a rising edge; t_start is the
    // cycle count at which the start bit was driven low.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                              output int t_start);
        bus.uart_rxd = 1'b0;
        t_start = cyc;
        tick(CPB);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par);
`else
        if (par === 1'bz) bus.uart_rxd = 1'b1;
`endif
        drive_bit(stop);
    endtask

    task automatic mark();
        #0;
        b_valid = n_valid;
        b_ferr  = n_ferr;
        b_perr  = n_perr;
    endtask

    initial begin
        vecs[0] = '{8'h00, 1'b1, 1, 0, 8'h00};
        vecs[1] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
        vecs[2] = '{8'h01, 1'b1, 1, 0, 8'h01};
        vecs[3] = '{8'h80, 1'b1, 1, 0, 8'h80};
        vecs[4] = '{8'h5A, 1'b0, 0, 1, 8'h80};
        vecs[5] = '{8'h96, 1'b1, 1, 0, 8'h96};

        // Reset with the line idle.
        bus.uart_rxd = 1'b1;
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data", 32'(bus.uart_rx_data), 32'h00);
        check("rst_valid", 32'(bus.uart_rx_valid), 32'h0);
        check("rst_busy", 32'(bus.uart_rx_busy), 32'h0);
        check("rst_ferr", 32'(bus.uart_rx_frame_err), 32'h0);
        check("rst_perr", 32'(bus.uart_rx_parity_err), 32'h0);
        reset_n = 1'b0;
        tick(4);

        // Single byte: latency and busy window.
        mark();
        send_frame(8'hA5, ^8'hA5, 1'b1, t0);
        tick(32);
        check("a5_count", n_valid - b_valid, 1);
        check("a5_data", 32'(bus.uart_rx_data), 32'hA5);
        check("a5_latency", valid_cyc - t0, LAT);
        check("a5_busy_rise", busy_rise_cyc - t0, SYNC + 1);
        check("a5_busy_fall", busy_fall_cyc - t0, LAT);
        check("a5_no_err", (n_ferr - b_ferr) + (n_perr - b_perr), 0);

        // Back-to-back frames with no idle gap.
        mark();
        send_frame(8'h3C, ^8'h3C, 1'b1, t0);
        send_frame(8'hC3, ^8'hC3, 1'b1, t0);
        tick(32);
        check("b2b_count", n_valid - b_valid, 2);
        check("b2b_first", 32'(got_log[b_valid % 64]), 32'h3C);
        check("b2b_second", 32'(got_log[(b_valid + 1) % 64]), 32'hC3);
        check("b2b_no_err", (n_ferr - b_ferr) + (n_perr - b_perr), 0);
        check("b2b_data", 32'(bus.uart_rx_data), 32'hC3);

        // Short low glitch rejected at the start mid-bit.
        mark();
        bus.uart_rxd = 1'b0;
        t0 = cyc;
        tick(4);
        bus.uart_rxd = 1'b1;
        tick(40);
        check("gl_busy_rise", busy_rise_cyc - t0, SYNC + 1);
        check("gl_busy_fall", busy_fall_cyc - t0, SYNC + 1 + HALF);
        check("gl_no_strobe", (n_valid - b_valid) + (n_ferr - b_ferr) + (n_perr - b_perr), 0);
        check("gl_data", 32'(bus.uart_rx_data), 32'hC3);
        check("gl_busy", 32'(bus.uart_rx_busy), 32'h0);

        // Stop bit low, then line held low: one frame error, no retrigger.
        mark();
        send_frame(8'h55, ^8'h55, 1'b0, t0);
        tick(20);
        check("fe_no_retrig", 32'(bus.uart_rx_busy), 32'h0);
        tick(20);
        bus.uart_rxd = 1'b1;
        tick(40);
        check("fe_count", n_ferr - b_ferr, 1);
        check("fe_cycle", ferr_cyc - t0, LAT);
        check("fe_no_valid", n_valid - b_valid, 0);
        check("fe_data", 32'(bus.uart_rx_data), 32'hC3);
        check("fe_busy", 32'(bus.uart_rx_busy), 32'h0);

        // Table of single frames.
        for (int i = 0; i < 6; i++) begin
            mark();
            send_frame(vecs[i].data, ^vecs[i].data, vecs[i].stop, t0);
            bus.uart_rxd = 1'b1;
            tick(32);
            check($sformatf("vec%0d_valid", i), n_valid - b_valid, vecs[i].exp_valid);
            check($sformatf("vec%0d_ferr", i), n_ferr - b_ferr, vecs[i].exp_ferr);
            check($sformatf("vec%0d_data", i), 32'(bus.uart_rx_data), 32'(vecs[i].exp_data));
        end

        // Reset during data bit 4 of 8'hFF.
        mark();
        bus.uart_rxd = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        tick(HALF);
        check("rm_busy_before", 32'(bus.uart_rx_busy), 32'h1);
        reset_n = 1'b1;
        #1;
        check("rm_busy_now", 32'(bus.uart_rx_busy), 32'h0);
        tick(3);
        reset_n = 1'b0;
        tick(40);
        check("rm_no_strobe", (n_valid - b_valid) + (n_ferr - b_ferr) + (n_perr - b_perr), 0);
        check("rm_data", 32'(bus.uart_rx_data), 32'h00);
        mark();
        send_frame(8'h12, ^8'h12, 1'b1, t0);
        tick(32);
        check("rm_after_count", n_valid - b_valid, 1);
        check("rm_after_data", 32'(bus.uart_rx_data), 32'h12);

`ifdef UART_RX_PARITY_EN
        mark();
        send_frame(8'h07, 1'b1, 1'b1, t0);
        tick(32);
        check("par_ok_valid", n_valid - b_valid, 1);
        check("par_ok_data", 32'(bus.uart_rx_data), 32'h07);
        check("par_ok_perr", n_perr - b_perr, 0);
        mark();
        send_frame(8'h07, 1'b0, 1'b1, t0);
        tick(32);
        check("par_bad_perr", n_perr - b_perr, 1);
        check("par_bad_valid", n_valid - b_valid, 0);
        check("par_bad_data", 32'(bus.uart_rx_data), 32'h07);
`else
        check("perr_never", n_perr, 0);
`endif
        check("strobe_overlap", n_overlap, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
